// File: rtl/image_receiver.sv
// UART 8N1 receiver that locks onto the start-of-frame marker and writes RGB444 pixels into a frame buffer.
// Optional stalled-frame abort is built when IMAGE_RECEIVER_TIMEOUT_EN is defined.
module image_receiver #(
   parameter int          NUM_PIXELS   = 76800,
   parameter int          BAUD_RATE    = 115200,
   parameter int          CLOCK_SPEED  = 50_000_000,
   parameter logic [11:0] START_PIXEL  = 12'h00A,
   parameter int          IDLE_TIMEOUT = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_in,
   output logic        wr_en,
   output logic [16:0] wr_address,
   output logic [11:0] wr_data,
   output logic        frame_done,
   output logic        receiving,
   output logic        error
);
   localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]      LAST_ADDR = 17'(NUM_PIXELS - 1);
   localparam logic [7:0]       MARK_HI   = {4'h0, START_PIXEL[11:8]};
   localparam logic [7:0]       MARK_LO   = START_PIXEL[7:0];

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {HUNT, PIX_HI, PIX_LO} fr_state_t;

   logic sync_a, sync_b, sync_c, rx_fall;
   rx_state_t rx_state, rx_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift, byte_dat;
   logic bit_end, half_end, cnt_clr, shift_en, stop_smp;
   logic byte_vld, frame_err;

   fr_state_t fr_state, fr_next;
   logic [7:0]  prev_byte;
   logic [3:0]  hi_nib;
   logic [16:0] addr_cnt;
   logic in_frame, lock, fmt_err, pix_wr, last_pix, abort, timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         sync_c <= 1'b1;
      end else begin
         sync_a <= uart_in;
         sync_b <= sync_a;
         sync_c <= sync_b;
      end
   end

   assign rx_fall  = sync_c & ~sync_b;
   assign bit_end  = (bit_cnt == BIT_END);
   assign half_end = (bit_cnt == HALF_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (half_end) rx_next = sync_b ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_end && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (bit_end) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      cnt_clr  = (rx_state == RX_IDLE) || (rx_next != rx_state) ||
                 (rx_state == RX_DATA && bit_end);
      shift_en = (rx_state == RX_DATA) && bit_end;
      stop_smp = (rx_state == RX_STOP) && bit_end;
   end

   // byte_vld / frame_err fire the cycle after the mid-stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_dat  <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         bit_cnt <= cnt_clr ? '0 : bit_cnt + CNT_W'(1);
         if (rx_state == RX_IDLE) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {sync_b, shift[7:1]};
         end
         byte_vld  <= stop_smp & sync_b;
         frame_err <= stop_smp & ~sync_b;
         if (stop_smp) byte_dat <= shift;
      end
   end

   assign in_frame = (fr_state != HUNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fr_state <= HUNT;
      else        fr_state <= fr_next;
   end

   always_comb begin
      fr_next = fr_state;
      case (fr_state)
         HUNT:    if (lock) fr_next = PIX_HI;
         PIX_HI:  if (abort || fmt_err) fr_next = HUNT;
                  else if (byte_vld)   fr_next = PIX_LO;
         PIX_LO:  if (abort || last_pix) fr_next = HUNT;
                  else if (byte_vld)     fr_next = PIX_HI;
         default: fr_next = HUNT;
      endcase
   end

   always_comb begin
      lock     = (fr_state == HUNT) && byte_vld && prev_byte == MARK_HI && byte_dat == MARK_LO;
      fmt_err  = (fr_state == PIX_HI) && byte_vld && byte_dat[7:4] != 4'h0;
      pix_wr   = (fr_state == PIX_LO) && byte_vld;
      last_pix = pix_wr && addr_cnt == LAST_ADDR;
      abort    = in_frame && (frame_err || timeout);
   end

   // prev_byte starts at a non-marker value so a lone 0x0A after reset cannot lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_byte  <= 8'hFF;
         hi_nib     <= '0;
         addr_cnt   <= '0;
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         receiving  <= 1'b0;
         error      <= 1'b0;
      end else begin
         wr_en      <= pix_wr;
         frame_done <= last_pix;
         if (byte_vld) prev_byte <= byte_dat;
         if (fr_state == PIX_HI && byte_vld) hi_nib <= byte_dat[3:0];
         if (lock)        addr_cnt <= '0;
         else if (pix_wr) addr_cnt <= addr_cnt + 17'd1;
         if (pix_wr) begin
            wr_address <= addr_cnt;
            wr_data    <= {hi_nib, byte_dat};
         end
         if (lock)                                  receiving <= 1'b1;
         else if (last_pix || fmt_err || abort)     receiving <= 1'b0;
         if (lock)                                  error <= 1'b0;
         else if (fmt_err || frame_err || timeout)  error <= 1'b1;
      end
   end

`ifdef IMAGE_RECEIVER_TIMEOUT_EN
   localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
   logic [TO_W-1:0] idle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    idle_cnt <= '0;
      else if (!in_frame || byte_vld) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + TO_W'(1);
   end

   assign timeout = in_frame && !byte_vld && idle_cnt == TO_W'(IDLE_TIMEOUT - 1);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_image_receiver.sv
// Self-checking bench for image_receiver: serial byte streams checked against a stream-level frame model.
module tb_image_receiver;
   localparam int          CPB     = 8;
   localparam int          BAUD    = 115200;
   localparam int          CLK_HZ  = BAUD * CPB;
   localparam int          NPIX    = 4;
   localparam int          IDLE_TO = 2000;
   localparam logic [11:0] MARKER  = 12'h00A;

   typedef struct packed {
      logic [16:0] addr;
      logic [11:0] data;
      logic        done;
   } wr_t;

   logic clk = 1'b0, rst_n = 1'b0, uart_in = 1'b1;
   logic wr_en, frame_done, receiving, error;
   logic [16:0] wr_address;
   logic [11:0] wr_data;

   wr_t  got_q[$], exp_q[$];
   int   got_cyc[$];
   logic [7:0] st_b[$];
   bit   st_bad[$];
   logic exp_err, exp_rcv;
   int   tests = 0, failed = 0, cyc = 0, stray_done = 0, last_start = 0;

   image_receiver #(
      .NUM_PIXELS(NPIX), .BAUD_RATE(BAUD), .CLOCK_SPEED(CLK_HZ),
      .START_PIXEL(MARKER), .IDLE_TIMEOUT(IDLE_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .wr_en(wr_en),
      .wr_address(wr_address), .wr_data(wr_data), .frame_done(frame_done),
      .receiving(receiving), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            got_q.push_back(wr_t'({wr_address, wr_data, frame_done}));
            got_cyc.push_back(cyc);
         end else if (frame_done) begin
            stray_done++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0d cycles, limit 200000", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      #1 rst_n = 1'b0;
      uart_in = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete(); got_cyc.delete(); st_b.delete(); st_bad.delete();
      stray_done = 0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad);
      st_b.push_back(b);
      st_bad.push_back(bad);
      @(posedge clk); #1;
      last_start = cyc;
      uart_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1 uart_in = b[i];
      end
      repeat (CPB) @(posedge clk);
      #1 uart_in = !bad;
      repeat (CPB) @(posedge clk);
      #1 uart_in = 1'b1;
      repeat (CPB + $urandom_range(0, CPB)) @(posedge clk);
   endtask

   task automatic send_pix(input logic [11:0] v);
      send_byte({4'h0, v[11:8]}, 1'b0);
      send_byte(v[7:0], 1'b0);
   endtask

   task automatic send_marker();
      send_pix(MARKER);
   endtask

   // Stream-level model: sliding marker search, then hi/lo byte pairs become sequential pixel writes.
   task automatic model_stream();
      int prev, phase, addr;
      logic [3:0] hi;
      prev = -1; phase = 0; addr = 0; hi = '0;
      exp_q.delete(); exp_err = 1'b0; exp_rcv = 1'b0;
      foreach (st_b[k]) begin
         if (st_bad[k]) begin
            exp_err = 1'b1; exp_rcv = 1'b0; phase = 0;
         end else begin
            if (phase == 0) begin
               if (prev == int'(MARKER[11:8]) && st_b[k] == MARKER[7:0]) begin
                  phase = 1; addr = 0; exp_err = 1'b0; exp_rcv = 1'b1;
               end
            end else if (phase == 1) begin
               if (st_b[k][7:4] != 4'h0) begin
                  exp_err = 1'b1; exp_rcv = 1'b0; phase = 0;
               end else begin
                  hi = st_b[k][3:0]; phase = 2;
               end
            end else begin
               exp_q.push_back(wr_t'({17'(addr), hi, st_b[k], addr == NPIX - 1}));
               if (addr == NPIX - 1) begin
                  exp_rcv = 1'b0; phase = 0;
               end else begin
                  phase = 1;
               end
               addr++;
            end
            prev = int'(st_b[k]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({wr_en, wr_address, wr_data, frame_done, receiving, error} !== 33'd0) begin
         failed++;
         $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h done=%b rcv=%b err=%b, expected all 0",
                  wr_en, wr_address, wr_data, frame_done, receiving, error);
      end
      rst_n = 1'b1;
      repeat (2000) @(posedge clk);
      #1;
      tests++;
      if (got_q.size() != 0) begin
         failed++; $display("FAIL reset_idle_writes: got %0d writes, expected 0", got_q.size());
      end
      tests++;
      if ({frame_done, receiving, error, stray_done != 0} !== 4'b0) begin
         failed++; $display("FAIL reset_idle_flags: got done=%b rcv=%b err=%b stray=%0d, expected 0", frame_done, receiving, error, stray_done);
      end
   endtask

   task automatic test_two_pixels();
      int lat;
      do_reset();
      send_marker();
      send_pix(12'hABC);
      lat = last_start;
      send_pix(12'h123);
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL two_pix_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
         tests++;
         if (got_q[k] !== exp_q[k]) begin
            failed++; $display("FAIL two_pix_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                               k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
         end
      end
      tests++;
      if (receiving !== 1'b1 || error !== 1'b0) begin
         failed++; $display("FAIL two_pix_flags: got rcv=%b err=%b, expected rcv=1 err=0", receiving, error);
      end
      if (got_cyc.size() > 0) begin
         lat = got_cyc[0] - lat;
         tests++;
         if (lat < CPB * 19 / 2 || lat > CPB * 19 / 2 + 8) begin
            failed++; $display("FAIL two_pix_latency: got %0d cycles from start bit, expected %0d..%0d", lat, CPB * 19 / 2, CPB * 19 / 2 + 8);
         end
      end
   endtask

   task automatic test_full_frame();
      do_reset();
      send_marker();
      for (int i = 0; i < NPIX; i++) send_pix(12'($urandom));
      repeat (4) @(posedge clk);
      #1;
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL full_frame_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
         tests++;
         if (got_q[k] !== exp_q[k]) begin
            failed++; $display("FAIL full_frame_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                               k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
         end
      end
      tests++;
      if (stray_done != 0) begin
         failed++; $display("FAIL full_frame_stray_done: got %0d pulses without a write, expected 0", stray_done);
      end
      tests++;
      if (receiving !== exp_rcv || error !== exp_err) begin
         failed++; $display("FAIL full_frame_flags: got rcv=%b err=%b, expected rcv=%b err=%b", receiving, error, exp_rcv, exp_err);
      end
   endtask

   task automatic test_garbage_lock();
      do_reset();
      repeat ($urandom_range(3, 6)) send_byte(8'($urandom_range(8'h10, 8'hFF)), 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      tests++;
      if (receiving !== 1'b0) begin
         failed++; $display("FAIL garbage_early_lock: got rcv=%b before marker low byte, expected 0", receiving);
      end
      send_byte(MARKER[7:0], 1'b0);
      send_pix(12'($urandom));
      send_pix(12'($urandom));
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL garbage_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
         tests++;
         if (got_q[k] !== exp_q[k]) begin
            failed++; $display("FAIL garbage_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                               k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
         end
      end
      tests++;
      if (receiving !== exp_rcv || error !== exp_err) begin
         failed++; $display("FAIL garbage_flags: got rcv=%b err=%b, expected rcv=%b err=%b", receiving, error, exp_rcv, exp_err);
      end
   endtask

   task automatic test_framing_error();
      do_reset();
      send_marker();
      send_pix(12'($urandom));
      send_byte(8'h04, 1'b1);
      tests++;
      if (error !== 1'b1 || receiving !== 1'b0) begin
         failed++; $display("FAIL framing_abort: got err=%b rcv=%b, expected err=1 rcv=0", error, receiving);
      end
      send_byte(8'h05, 1'b0);
      send_marker();
      tests++;
      if (error !== 1'b0 || receiving !== 1'b1) begin
         failed++; $display("FAIL framing_relock: got err=%b rcv=%b, expected err=0 rcv=1", error, receiving);
      end
      for (int i = 0; i < NPIX; i++) send_pix(12'($urandom));
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL framing_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
         tests++;
         if (got_q[k] !== exp_q[k]) begin
            failed++; $display("FAIL framing_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                               k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
         end
      end
      tests++;
      if (receiving !== exp_rcv || error !== exp_err) begin
         failed++; $display("FAIL framing_flags: got rcv=%b err=%b, expected rcv=%b err=%b", receiving, error, exp_rcv, exp_err);
      end
   endtask

   task automatic test_format_error();
      do_reset();
      send_marker();
      send_pix(12'($urandom));
      send_byte(8'h3F, 1'b0);
      send_byte(8'h12, 1'b0);
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL format_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      tests++;
      if (receiving !== exp_rcv || error !== exp_err) begin
         failed++; $display("FAIL format_flags: got rcv=%b err=%b, expected rcv=%b err=%b", receiving, error, exp_rcv, exp_err);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_marker();
      send_pix(MARKER);
      for (int i = 1; i < NPIX; i++) send_pix(12'($urandom));
      send_marker();
      for (int i = 0; i < NPIX; i++) send_pix(12'($urandom));
      model_stream();
      tests++;
      if (got_q.size() != exp_q.size()) begin
         failed++; $display("FAIL b2b_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
         tests++;
         if (got_q[k] !== exp_q[k]) begin
            failed++; $display("FAIL b2b_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                               k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
         end
      end
      tests++;
      if (receiving !== exp_rcv || error !== exp_err) begin
         failed++; $display("FAIL b2b_flags: got rcv=%b err=%b, expected rcv=%b err=%b", receiving, error, exp_rcv, exp_err);
      end
   endtask

   task automatic test_random();
      int r;
      for (int it = 0; it < 3; it++) begin
         do_reset();
         repeat ($urandom_range(14, 24)) begin
            r = $urandom_range(0, 9);
            if (r == 0)      send_marker();
            else if (r == 1) send_byte(8'($urandom), 1'b1);
            else if (r <= 5) send_pix(12'($urandom));
            else             send_byte(8'($urandom), 1'b0);
         end
         model_stream();
         tests++;
         if (got_q.size() != exp_q.size()) begin
            failed++; $display("FAIL random%0d_count: got %0d writes, expected %0d", it, got_q.size(), exp_q.size());
         end
         foreach (exp_q[k]) if (k < got_q.size()) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
               failed++; $display("FAIL random%0d_wr%0d: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                                  it, k, got_q[k].addr, got_q[k].data, got_q[k].done, exp_q[k].addr, exp_q[k].data, exp_q[k].done);
            end
         end
         tests++;
         if (receiving !== exp_rcv || error !== exp_err) begin
            failed++; $display("FAIL random%0d_flags: got rcv=%b err=%b, expected rcv=%b err=%b", it, receiving, error, exp_rcv, exp_err);
         end
      end
   endtask

   task automatic test_idle();
      do_reset();
      send_marker();
      send_pix(12'($urandom));
      tests++;
      if (got_q.size() != 1 || receiving !== 1'b1) begin
         failed++; $display("FAIL idle_setup: got %0d writes rcv=%b, expected 1 write rcv=1", got_q.size(), receiving);
      end
`ifdef IMAGE_RECEIVER_TIMEOUT_EN
      if (got_cyc.size() > 0) begin
         while (cyc < got_cyc[0] + IDLE_TO - 20) @(posedge clk);
         #1;
         tests++;
         if (error !== 1'b0 || receiving !== 1'b1) begin
            failed++; $display("FAIL idle_early_timeout: got err=%b rcv=%b, expected err=0 rcv=1", error, receiving);
         end
         repeat (40) @(posedge clk);
         #1;
         tests++;
         if (error !== 1'b1 || receiving !== 1'b0 || stray_done != 0) begin
            failed++; $display("FAIL idle_timeout: got err=%b rcv=%b stray=%0d, expected err=1 rcv=0 stray=0", error, receiving, stray_done);
         end
      end
`else
      repeat (IDLE_TO + 100) @(posedge clk);
      #1;
      tests++;
      if (error !== 1'b0 || receiving !== 1'b1) begin
         failed++; $display("FAIL idle_wait: got err=%b rcv=%b, expected err=0 rcv=1", error, receiving);
      end
`endif
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      send_marker();
      send_pix(12'($urandom));
      send_byte(8'h07, 1'b0);
      @(posedge clk); #1 uart_in = 1'b0;
      repeat (CPB * 5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({wr_en, wr_address, wr_data, frame_done, receiving, error} !== 33'd0) begin
         failed++;
         $display("FAIL midframe_reset_outputs: got wr_en=%b addr=%0d data=%h done=%b rcv=%b err=%b, expected all 0",
                  wr_en, wr_address, wr_data, frame_done, receiving, error);
      end
      uart_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (CPB * 12) @(posedge clk);
      #1;
      tests++;
      if (got_q.size() != 1 || receiving !== 1'b0) begin
         failed++; $display("FAIL midframe_partial: got %0d writes rcv=%b, expected 1 write rcv=0", got_q.size(), receiving);
      end
   endtask

   initial begin
      test_reset();
      test_two_pixels();
      test_full_frame();
      test_garbage_lock();
      test_framing_error();
      test_format_error();
      test_back_to_back();
      test_random();
      test_idle();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
